// File: rtl/sequence_mem_pkg.sv
// Shared types for the Simon Says sequence store.
// The playback engine walks IDLE -> SHOW -> DONE -> IDLE.
package sequence_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } play_state_t;

endpackage : sequence_mem_pkg

// File: rtl/sequence_mem_array.sv
// DEPTH x SYM_W symbol storage: one synchronous write port and two
// asynchronous read ports (random-access read and playback).
module sequence_mem_array #(
    parameter int SYM_W  = 2,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SYM_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [SYM_W-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [SYM_W-1:0]  rdata_b
);

    logic [SYM_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; slots beyond the tracked length are never
    // observed, so clearing them would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule : sequence_mem_array

// File: rtl/sequence_mem.sv
// Growing colour-sequence store: tail appends, registered random reads,
// and a handshaked playback stream of the whole stored sequence.
module sequence_mem
    import sequence_mem_pkg::*;
#(
    parameter int SYM_W  = 2,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              append_valid,
    input  logic [SYM_W-1:0]  append_sym,
    output logic              append_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [SYM_W-1:0]  rd_sym,
    output logic              rd_valid,
    input  logic              play_start,
    output logic [SYM_W-1:0]  play_sym,
    output logic              play_valid,
    input  logic              play_ready,
    output logic              play_busy,
    output logic              play_done,
    output logic [ADDR_W:0]   length,
    output logic              full
);

    localparam int              LEN_W     = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE   = LEN_W'(1);

    play_state_t       state_q;
    logic [ADDR_W:0]   length_q;
    logic [ADDR_W-1:0] idx_q;
    logic [SYM_W-1:0]  rd_sym_q;
    logic              rd_valid_q;
    logic [SYM_W-1:0]  play_sym_q;
    logic              play_valid_q;
    logic              play_done_q;

    logic              append_fire;
    logic              rd_in_range;
    logic              last_sym;
    logic [ADDR_W-1:0] play_raddr;
    logic [SYM_W-1:0]  rd_data;
    logic [SYM_W-1:0]  play_data;

    assign full         = (length_q == DEPTH_LEN);
    assign append_ready = !full && (state_q == IDLE) && !clear;
    assign append_fire  = append_valid && append_ready && !reset;
    assign rd_in_range  = ({1'b0, rd_addr} < length_q);
    assign last_sym     = ({1'b0, idx_q} == (length_q - LEN_ONE));

    // In IDLE the playback port pre-fetches slot 0; in SHOW it looks one ahead.
    assign play_raddr = (state_q == IDLE) ? '0 : idx_q + 1'b1;

    sequence_mem_array #(
        .SYM_W  (SYM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock   (clock),
        .we      (append_fire),
        .waddr   (length_q[ADDR_W-1:0]),
        .wdata   (append_sym),
        .raddr_a (rd_addr),
        .rdata_a (rd_data),
        .raddr_b (play_raddr),
        .rdata_b (play_data)
    );

    // NOTE: every sequential assignment uses <= so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_sym_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_sym_q   <= (rd_en && rd_in_range) ? rd_data : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            length_q     <= '0;
            idx_q        <= '0;
            play_sym_q   <= '0;
            play_valid_q <= 1'b0;
            play_done_q  <= 1'b0;
        end else if (clear) begin
            state_q      <= IDLE;
            length_q     <= '0;
            idx_q        <= '0;
            play_sym_q   <= '0;
            play_valid_q <= 1'b0;
            play_done_q  <= 1'b0;
        end else begin
            if (append_fire) begin
                length_q <= length_q + LEN_ONE;
            end
            case (state_q)
                IDLE: begin
                    play_done_q <= 1'b0;
                    if (play_start) begin
                        idx_q <= '0;
                        if (length_q != '0) begin
                            state_q      <= SHOW;
                            play_sym_q   <= play_data;
                            play_valid_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            play_done_q <= 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (play_ready) begin
                        if (last_sym) begin
                            state_q      <= DONE;
                            play_valid_q <= 1'b0;
                            play_done_q  <= 1'b1;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            play_sym_q <= play_data;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    play_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    play_valid_q <= 1'b0;
                    play_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_sym     = rd_sym_q;
    assign rd_valid   = rd_valid_q;
    assign play_sym   = play_sym_q;
    assign play_valid = play_valid_q;
    assign play_done  = play_done_q;
    assign play_busy  = (state_q != IDLE);
    assign length     = length_q;

endmodule : sequence_mem

// File: tb/tb_sequence_mem.sv
// Directed bench for sequence_mem: appends, reads, playback handshake,
// clear/reset interaction, with hand-computed expected values.
module tb_sequence_mem;

    localparam int SYM_W  = 2;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              clear;
    logic              append_valid;
    logic [SYM_W-1:0]  append_sym;
    logic              append_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [SYM_W-1:0]  rd_sym;
    logic              rd_valid;
    logic              play_start;
    logic [SYM_W-1:0]  play_sym;
    logic              play_valid;
    logic              play_ready;
    logic              play_busy;
    logic              play_done;
    logic [ADDR_W:0]   length;
    logic              full;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sequence_mem #(
        .SYM_W  (SYM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .append_valid (append_valid),
        .append_sym   (append_sym),
        .append_ready (append_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_sym       (rd_sym),
        .rd_valid     (rd_valid),
        .play_start   (play_start),
        .play_sym     (play_sym),
        .play_valid   (play_valid),
        .play_ready   (play_ready),
        .play_busy    (play_busy),
        .play_done    (play_done),
        .length       (length),
        .full         (full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_reset_state(input string tag);
        check({tag, ".length"}, 32'(length), 0);
        check({tag, ".full"}, 32'(full), 0);
        check({tag, ".append_ready"}, 32'(append_ready), 1);
        check({tag, ".play_valid"}, 32'(play_valid), 0);
        check({tag, ".play_sym"}, 32'(play_sym), 0);
        check({tag, ".play_busy"}, 32'(play_busy), 0);
        check({tag, ".play_done"}, 32'(play_done), 0);
        check({tag, ".rd_valid"}, 32'(rd_valid), 0);
        check({tag, ".rd_sym"}, 32'(rd_sym), 0);
    endtask

    logic [SYM_W-1:0] seq4 [4];
    logic [SYM_W-1:0] exp_sym;

    initial begin
        seq4[0] = 2'd3; seq4[1] = 2'd1; seq4[2] = 2'd0; seq4[3] = 2'd2;
        reset = 1'b1; clear = 1'b0; append_valid = 1'b0; append_sym = '0;
        rd_en = 1'b0; rd_addr = '0; play_start = 1'b0; play_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_idle_reset_state("reset");

        // Append 3,1,0,2
        for (int i = 0; i < 4; i++) begin
            append_valid = 1'b1; append_sym = seq4[i];
            check("append4.ready", 32'(append_ready), 1);
            tick();
            check("append4.length", 32'(length), 32'(i + 1));
        end
        append_valid = 1'b0;

        // Random-access reads, one-cycle latency; out-of-range index returns 0
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(i);
            tick();
            check("read.valid", 32'(rd_valid), 1);
            check("read.sym", 32'(rd_sym), 32'(seq4[i]));
        end
        rd_addr = 4'd5;
        tick();
        check("read_oob.valid", 32'(rd_valid), 1);
        check("read_oob.sym", 32'(rd_sym), 0);
        rd_en = 1'b0;
        tick();
        check("read_off.valid", 32'(rd_valid), 0);

        // Playback with play_ready held high
        play_ready = 1'b1; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("play_fast.valid", 32'(play_valid), 1);
            check("play_fast.sym", 32'(play_sym), 32'(seq4[i]));
            check("play_fast.busy", 32'(play_busy), 1);
            check("play_fast.done_early", 32'(play_done), 0);
            tick();
        end
        check("play_fast.done", 32'(play_done), 1);
        check("play_fast.valid_end", 32'(play_valid), 0);
        check("play_fast.busy_done", 32'(play_busy), 1);
        tick();
        check("play_fast.done_pulse", 32'(play_done), 0);
        check("play_fast.busy_end", 32'(play_busy), 0);

        // Playback with play_ready toggling; an append attempt mid-play is dropped
        play_ready = 1'b0; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("play_slow.valid", 32'(play_valid), 1);
            check("play_slow.sym", 32'(play_sym), 32'(seq4[i]));
            tick();
            check("play_slow.hold_valid", 32'(play_valid), 1);
            check("play_slow.hold_sym", 32'(play_sym), 32'(seq4[i]));
            play_ready = 1'b1;
            if (i == 1) begin
                append_valid = 1'b1; append_sym = 2'd2;
                check("play_slow.append_ready", 32'(append_ready), 0);
            end
            tick();
            play_ready = 1'b0; append_valid = 1'b0;
        end
        check("play_slow.done", 32'(play_done), 1);
        check("play_slow.valid_end", 32'(play_valid), 0);
        tick();
        check("play_slow.busy_end", 32'(play_busy), 0);
        check("play_slow.length", 32'(length), 4);

        // Clear mid-SHOW, with a simultaneous append that must be dropped
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("clear.valid_before", 32'(play_valid), 1);
        clear = 1'b1; append_valid = 1'b1; append_sym = 2'd1;
        check("clear.append_ready", 32'(append_ready), 0);
        tick();
        clear = 1'b0; append_valid = 1'b0;
        check("clear.valid", 32'(play_valid), 0);
        check("clear.length", 32'(length), 0);
        check("clear.busy", 32'(play_busy), 0);
        check("clear.done", 32'(play_done), 0);
        tick();
        check("clear.done_after", 32'(play_done), 0);

        // Playback of an empty sequence
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("empty.done", 32'(play_done), 1);
        check("empty.valid", 32'(play_valid), 0);
        check("empty.busy", 32'(play_busy), 1);
        tick();
        check("empty.done_pulse", 32'(play_done), 0);
        check("empty.busy_end", 32'(play_busy), 0);
        check("empty.valid_end", 32'(play_valid), 0);

        // Fill to DEPTH with symbol i%4, then an extra append is dropped
        for (int i = 0; i < DEPTH; i++) begin
            append_valid = 1'b1; append_sym = SYM_W'(i);
            tick();
            if (i == DEPTH - 2) check("fill.not_full", 32'(full), 0);
        end
        check("fill.full", 32'(full), 1);
        check("fill.length", 32'(length), 16);
        check("fill.append_ready", 32'(append_ready), 0);
        append_sym = 2'd3;
        tick();
        append_valid = 1'b0;
        check("fill.overflow_length", 32'(length), 16);
        rd_en = 1'b1; rd_addr = 4'd15;
        tick();
        check("fill.read15", 32'(rd_sym), 3);
        rd_addr = 4'd5;
        tick();
        check("fill.read5", 32'(rd_sym), 1);
        rd_en = 1'b0;

        // Full-length playback exercises the last index
        play_ready = 1'b1; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_sym = SYM_W'(i);
            check("play16.valid", 32'(play_valid), 1);
            check("play16.sym", 32'(play_sym), 32'(exp_sym));
            tick();
        end
        check("play16.done", 32'(play_done), 1);
        tick();
        check("play16.busy_end", 32'(play_busy), 0);

        // Reset mid-playback alongside append and read requests
        play_ready = 1'b0; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("rst_play.valid_before", 32'(play_valid), 1);
        reset = 1'b1; append_valid = 1'b1; append_sym = 2'd2; rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        reset = 1'b0; append_valid = 1'b0; rd_en = 1'b0;
        check_idle_reset_state("rst_play");

        // Reset while idle together with an append: the append must not land
        reset = 1'b1; append_valid = 1'b1; append_sym = 2'd1;
        tick();
        reset = 1'b0; append_valid = 1'b0;
        check("rst_append.length", 32'(length), 0);
        check("rst_append.append_ready", 32'(append_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sequence_mem

// File: doc/sequence_mem.md
# sequence_mem

Parametrised sequence store for the Simon Says game: holds the growing colour sequence, accepts appends at the tail, serves random-access reads, and plays the whole stored sequence back as a handshaked stream to the display/tone logic. Successor to the fixed 2-bit × 16 read/write memory: width and depth are configurable, it tracks its own length, and it adds clear, full detection and a playback engine.

## Interface
- SYM_W, 2, bits per symbol (colour code)
- DEPTH, 16, maximum sequence length (≥2)
- ADDR_W, $clog2(DEPTH), index width; length uses ADDR_W+1 bits
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  empty the sequence (sync), aborts playback
- append_valid  in  1  request to append append_sym
- append_sym  in  SYM_W  symbol to append
- append_ready  out  1  append accepted this cycle if valid
- rd_en  in  1  random-access read request
- rd_addr  in  ADDR_W  read index
- rd_sym  out  SYM_W  read data
- rd_valid  out  1  rd_sym valid
- play_start  in  1  start playback of whole sequence
- play_sym  out  SYM_W  current playback symbol
- play_valid  out  1  play_sym valid
- play_ready  in  1  consumer accepts play_sym
- play_busy  out  1  playback in progress
- play_done  out  1  one-cycle pulse after last symbol accepted
- length  out  ADDR_W+1  number of stored symbols
- full  out  1  length == DEPTH

## Operation
- Reset: length 0, state IDLE, rd_sym/rd_valid/play_sym/play_valid/play_done 0, play_busy 0, full 0; append_ready 1. Storage contents not reset.
- append_ready = !full && state==IDLE && !clear (combinational). Accept: mem[length] <= append_sym, length <= length+1.
- Read: rd_en registers rd_sym/rd_valid next cycle; rd_addr ≥ length (sampled same cycle) returns rd_sym=0 with rd_valid=1. rd_valid=0 when rd_en=0. Reads legal in any state.
- Playback FSM (states in package): IDLE, SHOW, DONE.
  - IDLE + play_start, length>0 → SHOW, idx=0; play_sym=mem[0], play_valid=1 next cycle.
  - IDLE + play_start, length==0 → DONE (no play_valid).
  - SHOW: hold play_sym/play_valid stable until play_ready. On accept with idx==length-1 → DONE; else idx+1, next symbol presented next cycle with play_valid held high (one symbol/cycle max).
  - DONE: play_done=1 for exactly one cycle → IDLE.
  - play_busy=1 in SHOW and DONE. play_start ignored outside IDLE.
- Priority: reset > clear > append/playback. clear in any state: length←0, state←IDLE, play_valid←0, no play_done. clear and append_valid same cycle: append dropped.
- append_valid when full or busy: dropped, length unchanged.

## Timing
- Append: length visible updated cycle after accept; full asserts the same cycle length reaches DEPTH.
- Read latency 1 cycle; append to index k readable from the cycle after accept.
- Playback: play_start at cycle t → play_valid at t+1; with play_ready held high, N symbols on t+1..t+N, play_done at t+N+1, play_busy falls at t+N+2.
- Length 0 playback: play_done at t+1.

## Structure
- Package sequence_mem_pkg: play_state_t enum (IDLE, SHOW, DONE).
- Sub-module sequence_mem_array: DEPTH×SYM_W flop array, one write port, two asynchronous read ports (random read, playback); registering done in sequence_mem.

## Test plan
- Reset, append 3,1,0,2 (SYM_W=2) → length 4, rd_addr 0..3 gives 3,1,0,2 one cycle after each rd_en; rd_addr 5 → 0.
- Append 16 symbols → full=1, append_ready=0; 17th append dropped, length stays 16.
- Play 4-symbol sequence with play_ready high → play_sym 3,1,0,2 on consecutive cycles, play_done one cycle after; with play_ready toggling each cycle, each symbol held until accepted.
- play_start with length 0 → play_done next cycle, play_valid never 1.
- append_valid during playback → dropped; clear mid-SHOW → play_valid 0 next cycle, length 0, no play_done.
- reset asserted mid-playback and concurrently with append → all outputs return to reset values, length 0.
